// File: rtl/decoder_pkg.sv
// Shared definitions for the N-to-2^N decoder family: mode encodings, FSM
// states and the index-to-line-vector helper used by every decode path.
package decoder_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_PULSE  = 2'b01;
    localparam logic [1:0] MODE_SCAN   = 2'b10;

    // Widest select the helper supports; instances must use SEL_W < MAX_SEL_W.
    localparam int MAX_SEL_W = 10;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_PULSE,
        ST_SCAN
    } dec_state_t;

    // Reserved encoding 11 behaves as direct decode.
    function automatic dec_state_t mode_state(input logic [1:0] mode);
        case (mode)
            MODE_PULSE: return ST_PULSE;
            MODE_SCAN:  return ST_SCAN;
            default:    return ST_DIRECT;
        endcase
    endfunction

    function automatic logic [MAX_OUT_W-1:0] onehot_line(
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 active_low
    );
        logic [MAX_OUT_W-1:0] v;
        v      = {MAX_OUT_W{active_low}};
        v[idx] = ~active_low;
        return v;
    endfunction

endpackage

// File: rtl/decoder_nxm_core.sv
// Combinational index + enable + polarity to line vector; when disabled the
// vector is the idle pattern, so the result is always one-hot or idle.
module decoder_nxm_core
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [SEL_W-1:0]      idx,
    input  logic                  en,
    output logic [(2**SEL_W)-1:0] line
);

    localparam int OUT_W = 2**SEL_W;

    logic [MAX_OUT_W-1:0]     full_line;
    logic [MAX_OUT_W-1:OUT_W] unused_hi;

    always_comb begin
        full_line = onehot_line(MAX_SEL_W'(idx), ACTIVE_LOW);
        line      = en ? full_line[OUT_W-1:0] : {OUT_W{ACTIVE_LOW}};
    end

    assign unused_hi = full_line[MAX_OUT_W-1:OUT_W];

endmodule

// File: rtl/decoder_nxm_scan.sv
// Registered N-to-2^N decoder with direct, pulse and scan modes. The FSM
// decides which line (if any) to assert next; all outputs come from flops.
module decoder_nxm_scan
    import decoder_pkg::*;
#(
    parameter int SEL_W      = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    parameter int DWELL_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  sel_valid,
    input  logic [DWELL_W-1:0]    dwell,
    output logic [(2**SEL_W)-1:0] D,
    output logic [SEL_W-1:0]      cur_idx,
    output logic                  busy,
    output logic                  wrap
);

    localparam int               OUT_W  = 2**SEL_W;
    localparam logic [OUT_W-1:0] IDLE_V = {OUT_W{ACTIVE_LOW}};

    dec_state_t         state_q, state_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SEL_W-1:0]   scan_idx_q, scan_idx_d;
    logic [OUT_W-1:0]   d_q, d_d;
    logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
    logic               busy_q, busy_d;
    logic               wrap_q, wrap_d;

    logic               line_en;
    logic [SEL_W-1:0]   line_idx;

    always_comb begin
        state_d     = ST_IDLE;
        dwell_cnt_d = '0;
        scan_idx_d  = '0;
        line_en     = 1'b0;
        line_idx    = '0;
        busy_d      = 1'b0;
        wrap_d      = 1'b0;

        if (enable) begin
            // The target state is taken straight from mode, so a mode change
            // lands on the very next edge with the new behaviour.
            state_d = mode_state(mode);
            case (state_d)
                ST_PULSE: begin
                    line_en  = sel_valid;
                    line_idx = sel_valid ? sel : '0;
                    busy_d   = sel_valid;
                end
                ST_SCAN: begin
                    line_en = 1'b1;
                    busy_d  = 1'b1;
                    if (state_q != ST_SCAN) begin
                        scan_idx_d  = '0;
                        dwell_cnt_d = dwell;
                    end else if (dwell_cnt_q == '0) begin
                        scan_idx_d  = scan_idx_q + 1'b1;
                        dwell_cnt_d = dwell;
                        wrap_d      = &scan_idx_q;
                    end else begin
                        scan_idx_d  = scan_idx_q;
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end
                    line_idx = scan_idx_d;
                end
                default: begin
                    line_en  = 1'b1;
                    line_idx = sel;
                end
            endcase
        end

        cur_idx_d = line_idx;
    end

    decoder_nxm_core #(
        .SEL_W      (SEL_W),
        .ACTIVE_LOW (ACTIVE_LOW)
    ) u_core (
        .idx  (line_idx),
        .en   (line_en),
        .line (d_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            dwell_cnt_q <= '0;
            scan_idx_q  <= '0;
            d_q         <= IDLE_V;
            cur_idx_q   <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dwell_cnt_q <= dwell_cnt_d;
            scan_idx_q  <= scan_idx_d;
            d_q         <= d_d;
            cur_idx_q   <= cur_idx_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    assign D       = d_q;
    assign cur_idx = cur_idx_q;
    assign busy    = busy_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_decoder_nxm_scan.sv
// Scoreboard bench for decoder_nxm_scan: an active-low and an active-high
// instance share stimulus; expected outputs are queued per driven cycle.
module tb_decoder_nxm_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [1:0] sel = 2'b00;
    logic       sel_valid = 1'b0;
    logic [7:0] dwell = 8'd0;

    logic [3:0] d_lo, d_hi;
    logic [1:0] idx_lo, idx_hi;
    logic       busy_lo, busy_hi, wrap_lo, wrap_hi;

    typedef struct {
        logic [3:0] d;
        logic [1:0] idx;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Active-low line patterns for lines 0..3.
    logic [3:0] lo_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    always #5 clk = ~clk;

    decoder_nxm_scan #(.SEL_W(2), .ACTIVE_LOW(1'b1), .DWELL_W(8)) u_dut_lo (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .dwell(dwell),
        .D(d_lo), .cur_idx(idx_lo), .busy(busy_lo), .wrap(wrap_lo)
    );

    decoder_nxm_scan #(.SEL_W(2), .ACTIVE_LOW(1'b0), .DWELL_W(8)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .sel(sel),
        .sel_valid(sel_valid), .dwell(dwell),
        .D(d_hi), .cur_idx(idx_hi), .busy(busy_hi), .wrap(wrap_hi)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".D"},      32'(d_lo),    32'hF);
        check({tag, ".D_hi"},   32'(d_hi),    32'h0);
        check({tag, ".idx"},    32'(idx_lo),  32'h0);
        check({tag, ".busy"},   32'(busy_lo), 32'h0);
        check({tag, ".wrap"},   32'(wrap_lo), 32'h0);
    endtask

    // Drive one cycle of stimulus, queue the expected result, compare after the edge.
    task automatic cycle(input logic en, input logic [1:0] md, input logic [1:0] s,
                         input logic sv, input logic [7:0] dw,
                         input logic [3:0] ed, input logic [1:0] ei,
                         input logic eb, input logic ew, input string tag);
        exp_t       e;
        logic [3:0] inv;
        enable    = en;
        mode      = md;
        sel       = s;
        sel_valid = sv;
        dwell     = dw;
        e.d = ed; e.idx = ei; e.busy = eb; e.wrap = ew;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e   = exp_q.pop_front();
        inv = ~e.d;
        $display("%0t %-10s D=%b D_hi=%b idx=%0d busy=%b wrap=%b (exp D=%b idx=%0d busy=%b wrap=%b)",
                 $time, tag, d_lo, d_hi, idx_lo, busy_lo, wrap_lo, e.d, e.idx, e.busy, e.wrap);
        check({tag, ".D"},       32'(d_lo),    32'(e.d));
        check({tag, ".D_hi"},    32'(d_hi),    32'(inv));
        check({tag, ".idx"},     32'(idx_lo),  32'(e.idx));
        check({tag, ".idx_hi"},  32'(idx_hi),  32'(e.idx));
        check({tag, ".busy"},    32'(busy_lo), 32'(e.busy));
        check({tag, ".busy_hi"}, 32'(busy_hi), 32'(e.busy));
        check({tag, ".wrap"},    32'(wrap_lo), 32'(e.wrap));
        check({tag, ".wrap_hi"}, 32'(wrap_hi), 32'(e.wrap));
    endtask

    task automatic idle_cycle(input string tag);
        cycle(1'b0, 2'b10, 2'(sel + 2'd1), 1'b1, 8'd3, 4'hF, 2'd0, 1'b0, 1'b0, tag);
    endtask

    // One scan line: the entry edge samples dv_entry, so the line lasts dv_entry+1
    // cycles; dv_rest is driven mid-line and must be ignored. sel/sel_valid are noise.
    task automatic scan_line(input int line, input int dv_entry, input int dv_rest, input logic w);
        for (int k = 0; k <= dv_entry; k++) begin
            cycle(1'b1, 2'b10, 2'($urandom_range(0, 3)), 1'b1,
                  8'((k == 0) ? dv_entry : dv_rest),
                  lo_tab[2'(line)], 2'(line), 1'b1, (k == 0) && w, "scan");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #12;
        check_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 4; s++)
            cycle(1'b0, 2'b00, 2'(s), 1'b1, 8'd0, 4'hF, 2'd0, 1'b0, 1'b0, "disabled");

        for (int s = 0; s < 4; s++)
            cycle(1'b1, 2'b00, 2'(s), 1'b0, 8'd0, lo_tab[s], 2'(s), 1'b0, 1'b0, "direct");
        cycle(1'b1, 2'b11, 2'd2, 1'b1, 8'd0, lo_tab[2], 2'd2, 1'b0, 1'b0, "reserved");

        cycle(1'b1, 2'b01, 2'd2, 1'b0, 8'd0, 4'hF,      2'd0, 1'b0, 1'b0, "pulse_nv");
        cycle(1'b1, 2'b01, 2'd2, 1'b1, 8'd0, lo_tab[2], 2'd2, 1'b1, 1'b0, "pulse");
        cycle(1'b1, 2'b01, 2'd2, 1'b0, 8'd0, 4'hF,      2'd0, 1'b0, 1'b0, "pulse_off");
        cycle(1'b1, 2'b01, 2'd1, 1'b1, 8'd0, lo_tab[1], 2'd1, 1'b1, 1'b0, "pulse_b2b");
        cycle(1'b1, 2'b01, 2'd3, 1'b1, 8'd0, lo_tab[3], 2'd3, 1'b1, 1'b0, "pulse_b2b");
        cycle(1'b1, 2'b01, 2'd3, 1'b0, 8'd0, 4'hF,      2'd0, 1'b0, 1'b0, "pulse_off");

        idle_cycle("to_idle");
        scan_line(0, 2, 2, 1'b0);
        scan_line(1, 2, 2, 1'b0);
        scan_line(2, 2, 2, 1'b0);
        scan_line(3, 2, 2, 1'b0);
        scan_line(0, 2, 0, 1'b1);
        for (int lap = 0; lap < 2; lap++) begin
            scan_line(1, 0, 0, 1'b0);
            scan_line(2, 0, 0, 1'b0);
            scan_line(3, 0, 0, 1'b0);
            scan_line(0, 0, 0, 1'b1);
        end

        idle_cycle("to_idle");
        scan_line(0, 1, 1, 1'b0);
        scan_line(1, 1, 1, 1'b0);
        cycle(1'b1, 2'b10, 2'd0, 1'b0, 8'd1, lo_tab[2], 2'd2, 1'b1, 1'b0, "scan_l2");
        cycle(1'b0, 2'b10, 2'd0, 1'b0, 8'd1, 4'hF,      2'd0, 1'b0, 1'b0, "drop_en");
        cycle(1'b1, 2'b10, 2'd0, 1'b0, 8'd1, lo_tab[0], 2'd0, 1'b1, 1'b0, "restart");

        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        @(posedge clk);
        #1;
        check_idle("rst_held");
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b1;

        scan_line(0, 0, 0, 1'b0);
        scan_line(1, 0, 0, 1'b0);
        scan_line(2, 0, 0, 1'b0);
        scan_line(3, 0, 0, 1'b0);
        cycle(1'b1, 2'b00, 2'd1, 1'b0, 8'd0, lo_tab[1], 2'd1, 1'b0, 1'b0, "switch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
